// File: rtl/lo_seq_ctrl.sv
// LO table address sequencer: phase accumulator with programmable step, start phase
// and burst length. Define LO_QUAD_EN to add the quadrature (cosine) address output.
module lo_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_step,
  input  logic [ADDR_W-1:0] cfg_phase,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] lut_addr,
  output logic              sample_valid
`ifdef LO_QUAD_EN
  ,
  output logic [ADDR_W-1:0] lut_addr_q
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] step_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_d;
  logic              cfg_fire;
  logic              launch;
  logic              last;

  assign cfg_fire = cfg_valid & cfg_ready & (state == IDLE);
  assign launch   = (state == IDLE) & start & ~stop;
  // cnt holds the number of samples already issued; len 0 never matches
  assign last     = (len_r != '0) && (cnt == len_r);

  // A same-cycle config write feeds the launching burst directly
  always_comb begin
    addr_d = lut_addr;
    if (launch)
      addr_d = cfg_fire ? cfg_phase : lut_addr_phase();
    else if ((state == RUN) && !stop && !last)
      addr_d = lut_addr + step_r;
  end

  logic [ADDR_W-1:0] phase_r;
  function automatic logic [ADDR_W-1:0] lut_addr_phase();
    return phase_r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      step_r       <= ADDR_W'(1);
      phase_r      <= '0;
      len_r        <= LEN_W'(16);
      cnt          <= '0;
      lut_addr     <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_ready    <= 1'b0;
    end else begin
      done     <= 1'b0;
      lut_addr <= addr_d;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_fire) begin
            step_r  <= cfg_step;
            phase_r <= cfg_phase;
            len_r   <= cfg_len;
          end
          if (launch) begin
            state        <= RUN;
            cnt          <= LEN_W'(1);
            sample_valid <= 1'b1;
            busy         <= 1'b1;
            cfg_ready    <= 1'b0;
          end
        end
        default: begin
          if (stop || last) begin
            state        <= IDLE;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            cfg_ready    <= 1'b1;
            done         <= ~stop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef LO_QUAD_EN
  localparam logic [ADDR_W-1:0] QOFF = ADDR_W'(1 << (ADDR_W - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lut_addr_q <= QOFF;
    else     lut_addr_q <= addr_d + QOFF;
  end
`endif

endmodule

// File: tb/tb_lo_seq_ctrl.sv
// Scoreboard bench for lo_seq_ctrl: driver pushes timed expected events, monitor pops them.
module tb_lo_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_step = '0;
  logic [3:0] cfg_phase = '0;
  logic [7:0] cfg_len = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy, done, sample_valid;
  logic [3:0] lut_addr;
`ifdef LO_QUAD_EN
  logic [3:0] lut_addr_q;
`endif

  lo_seq_ctrl #(.ADDR_W(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_step(cfg_step), .cfg_phase(cfg_phase), .cfg_len(cfg_len),
    .start(start), .stop(stop), .busy(busy), .done(done),
    .lut_addr(lut_addr), .sample_valid(sample_valid)
`ifdef LO_QUAD_EN
    , .lut_addr_q(lut_addr_q)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int addr;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  m_step = 1, m_phase = 0, m_len = 16;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid sample or done pulse must match the head of the queue
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_event: got none expected %s at cycle %0d",
                 q[0].is_done ? "done" : "sample", q[0].cyc);
        void'(q.pop_front());
      end
      if (sample_valid || done) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL unexpected_output: got valid=%0d done=%0d addr=%0d expected nothing at cycle %0d",
                   sample_valid, done, lut_addr, cyc);
        end else begin
          ev_t ev;
          ev = q.pop_front();
          chk("done", int'(done), int'(ev.is_done));
          chk("sample_valid", int'(sample_valid), int'(!ev.is_done));
          chk("busy", int'(busy), int'(!ev.is_done));
          if (!ev.is_done) begin
            chk("lut_addr", int'(lut_addr), ev.addr);
`ifdef LO_QUAD_EN
            chk("lut_addr_q", int'(lut_addr_q), (ev.addr + 4) % 16);
`endif
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called just after a negedge with the DUT idle. stop_k>0 stops after stop_k samples.
  task automatic run_burst(input bit do_cfg, input int s, input int p, input int l,
                           input int stop_k, input bit mid_cfg);
    int c0, n, end_c;
    chk("cfg_ready_idle", int'(cfg_ready), 1);
    if (do_cfg) begin
      cfg_valid = 1'b1;
      cfg_step  = 4'(s);
      cfg_phase = 4'(p);
      cfg_len   = 8'(l);
      m_step = s; m_phase = p; m_len = l;
    end
    start = 1'b1;
    c0 = cyc;
    n = (stop_k > 0) ? stop_k : m_len;
    for (int k = 0; k < n; k++) q.push_back('{0, (m_phase + k * m_step) % 16, c0 + 1 + k});
    if (stop_k > 0) end_c = c0 + n;
    else begin
      q.push_back('{1, 0, c0 + 1 + n});
      end_c = c0 + 1 + n;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    if (mid_cfg) begin
      chk("cfg_ready_run", int'(cfg_ready), 0);
      cfg_valid = 1'b1;
      cfg_step  = 4'(m_step + 7);
      cfg_phase = 4'(m_phase + 3);
      cfg_len   = 8'(m_len + 2);
      start = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b0;
    end
    if (stop_k > 0) begin
      wait_cyc(c0 + n);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    wait_cyc(end_c + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    @(negedge clk);
    chk("rst_lut_addr", int'(lut_addr), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
`ifdef LO_QUAD_EN
    chk("rst_lut_addr_q", int'(lut_addr_q), 4);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_burst(0, 0, 0, 0, 0, 0);           // defaults: 0..15, done on cycle 17
    run_burst(1, 3, 2, 6, 0, 0);           // 2,5,8,11,14,1
    run_burst(1, 5, 0, 0, 20, 0);          // continuous, stop after 20
    run_burst(1, 1, 14, 4, 0, 0);          // wrap 14,15,0,1
    run_burst(1, 2, 7, 5, 5, 0);           // stop on final sample: no done
    run_burst(1, 0, 9, 3, 0, 0);           // step 0: constant address
    run_burst(1, 4, 1, 6, 0, 1);           // cfg write + start during RUN ignored
    run_burst(0, 0, 0, 0, 0, 0);           // config still the pre-RUN one

    // start+stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("cfg_ready_after_startstop", int'(cfg_ready), 1);

    // start held high: bursts repeat with one gap (the done cycle)
    cfg_valid = 1'b1; cfg_step = 4'd3; cfg_phase = 4'd1; cfg_len = 8'd3;
    m_step = 3; m_phase = 1; m_len = 3;
    start = 1'b1;
    c0 = cyc;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 3; k++) q.push_back('{0, (1 + k * 3) % 16, c0 + b * 4 + 1 + k});
      q.push_back('{1, 0, c0 + b * 4 + 4});
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_cyc(c0 + 9);
    start = 1'b0;
    wait_cyc(c0 + 14);

    // random bursts
    for (int i = 0; i < 25; i++) begin
      int s, p, l, sk;
      bit dc;
      dc = ($urandom_range(0, 2) != 0);
      s = $urandom_range(0, 15);
      p = $urandom_range(0, 15);
      l = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
      if (!dc && m_len == 0) dc = 1'b1;
      if (dc) n = l; else n = m_len;
      if (n == 0) sk = $urandom_range(1, 25);
      else sk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      run_burst(dc, s, p, l, sk, 0);
    end

    // reset mid-burst at sample 7
    cfg_valid = 1'b1; cfg_step = 4'd3; cfg_phase = 4'd5; cfg_len = 8'd16;
    start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 16; k++) q.push_back('{0, (5 + k * 3) % 16, c0 + 1 + k});
    q.push_back('{1, 0, c0 + 17});
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    wait_cyc(c0 + 8);
    #1 rst = 1'b1;
    #1;
    chk("midrst_lut_addr", int'(lut_addr), 0);
    chk("midrst_valid", int'(sample_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cfg_ready", int'(cfg_ready), 0);
    q.delete();
    m_step = 1; m_phase = 0; m_len = 16;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);            // a stray done here would be flagged
    run_burst(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
